pwm_profile_sequencer: RTL and testbench

//   Steps the 8-bit PWM generator through a programmable profile of (set, clr, reload)

---
 rtl/pwm_profile_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pwm_profile_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_profile_sequencer.sv
// Walks the PWM generator through a small table of (set, clr, reload) steps,
// holding each step for a programmed number of PWM periods tracked by a mirror counter.
module pwm_profile_sequencer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              res_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [23:0]       wr_data_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [7:0]        repeat_i,
  input  logic [ADDR_W-1:0] last_idx_i,
  output logic [7:0]        set_thres_o,
  output logic [7:0]        clr_thres_o,
  output logic [7:0]        reload_o,
  output logic [ADDR_W-1:0] step_o,
  output logic              busy_o,
  output logic              period_end_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [23:0]       tbl_q [DEPTH];
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic [7:0]        rep_q, rep_d;
  logic [7:0]        set_q, set_d;
  logic [7:0]        clr_q, clr_d;
  logic [7:0]        reload_q, reload_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [7:0]        rep_cfg_q, rep_cfg_d;
  logic              loop_cfg_q, loop_cfg_d;
  logic [ADDR_W-1:0] last_cfg_q, last_cfg_d;

  logic              wrap;
  logic [8:0]        rep_tgt;
  logic              step_end;
  logic              at_last;

  // Profile table: writable at any time, read only when a step is loaded.
  always_ff @(posedge clk) begin
    if (res_i) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (wr_en_i) begin
      tbl_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign wrap     = (pcnt_q == reload_q);
  assign rep_tgt  = (rep_cfg_q == 8'd0) ? 9'd1 : {1'b0, rep_cfg_q};
  assign step_end = wrap && (({1'b0, rep_q} + 9'd1) >= rep_tgt);
  assign at_last  = (idx_q == last_cfg_q);

  always_ff @(posedge clk) begin
    if (res_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i && !stop_i) state_d = S_LOAD;
      S_LOAD: state_d = stop_i ? S_IDLE : S_RUN;
      S_RUN: begin
        if (stop_i)                      state_d = S_IDLE;
        else if (step_end && at_last && !loop_cfg_q) state_d = S_DONE;
        else if (step_end)               state_d = S_LOAD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == S_LOAD) || (state_q == S_RUN);
    done_o       = (state_q == S_DONE);
    period_end_o = (state_q == S_RUN) && wrap;
  end

  always_comb begin
    idx_d      = idx_q;
    pcnt_d     = pcnt_q;
    rep_d      = rep_q;
    set_d      = set_q;
    clr_d      = clr_q;
    reload_d   = reload_q;
    step_d     = step_q;
    rep_cfg_d  = rep_cfg_q;
    loop_cfg_d = loop_cfg_q;
    last_cfg_d = last_cfg_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          idx_d      = '0;
          rep_cfg_d  = repeat_i;
          loop_cfg_d = loop_i;
          last_cfg_d = last_idx_i;
        end
      end
      S_LOAD: begin
        if (stop_i) begin
          set_d    = '0;
          clr_d    = '0;
          reload_d = '0;
        end else begin
          {reload_d, clr_d, set_d} = tbl_q[idx_q];
          step_d = idx_q;
          pcnt_d = '0;
          rep_d  = '0;
        end
      end
      S_RUN: begin
        // Zero thresholds park the PWM output low on abort.
        if (stop_i) begin
          set_d    = '0;
          clr_d    = '0;
          reload_d = '0;
        end else if (wrap) begin
          pcnt_d = '0;
          rep_d  = rep_q + 8'd1;
          if (step_end) idx_d = at_last ? '0 : idx_q + ADDR_W'(1);
        end else begin
          pcnt_d = pcnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res_i) begin
      idx_q      <= '0;
      pcnt_q     <= '0;
      rep_q      <= '0;
      set_q      <= '0;
      clr_q      <= '0;
      reload_q   <= '0;
      step_q     <= '0;
      rep_cfg_q  <= '0;
      loop_cfg_q <= 1'b0;
      last_cfg_q <= '0;
    end else begin
      idx_q      <= idx_d;
      pcnt_q     <= pcnt_d;
      rep_q      <= rep_d;
      set_q      <= set_d;
      clr_q      <= clr_d;
      reload_q   <= reload_d;
      step_q     <= step_d;
      rep_cfg_q  <= rep_cfg_d;
      loop_cfg_q <= loop_cfg_d;
      last_cfg_q <= last_cfg_d;
    end
  end

  assign set_thres_o = set_q;
  assign clr_thres_o = clr_q;
  assign reload_o    = reload_q;
  assign step_o      = step_q;

endmodule

// File: tb/tb_pwm_profile_sequencer.sv
// Directed bench for pwm_profile_sequencer: timeline checks against hand-derived cycle numbers.
module tb_pwm_profile_sequencer;

  logic        clk = 1'b0;
  logic        res_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [1:0]  wr_addr_i = '0;
  logic [23:0] wr_data_i = '0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        loop_i = 1'b0;
  logic [7:0]  repeat_i = '0;
  logic [1:0]  last_idx_i = '0;
  logic [7:0]  set_thres_o, clr_thres_o, reload_o;
  logic [1:0]  step_o;
  logic        busy_o, period_end_o, done_o;

  int errs = 0;
  int checks = 0;

  pwm_profile_sequencer #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .res_i(res_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
    .repeat_i(repeat_i), .last_idx_i(last_idx_i), .set_thres_o(set_thres_o),
    .clr_thres_o(clr_thres_o), .reload_o(reload_o), .step_o(step_o),
    .busy_o(busy_o), .period_end_o(period_end_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [7:0] rl, input logic [7:0] cl,
                             input logic [7:0] st);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = {rl, cl, st};
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic test_reset();
    res_i = 1'b1;
    tick();
    tick();
    res_i = 1'b0;
    checks++;
    if ({set_thres_o, clr_thres_o, reload_o} !== 24'h0) begin
      errs++; $display("FAIL reset_thres got=%h exp=000000", {set_thres_o, clr_thres_o, reload_o});
    end
    checks++;
    if ({step_o, busy_o, period_end_o, done_o} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl got=%b exp=00000", {step_o, busy_o, period_end_o, done_o});
    end
  endtask

  // e0={9,5,0}, e1={9,2,0}, repeat=2, no loop; start at k=1 sample.
  task automatic test_single();
    logic exp_pe, exp_busy, exp_done;
    write_entry(2'd0, 8'd9, 8'd5, 8'd0);
    write_entry(2'd1, 8'd9, 8'd2, 8'd0);
    repeat_i = 8'd2; last_idx_i = 2'd1; loop_i = 1'b0;
    start_i = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      start_i  = (k == 9);
      if (k == 1) begin repeat_i = 8'd7; loop_i = 1'b1; end
      exp_pe   = (k == 11) || (k == 21) || (k == 32) || (k == 42);
      exp_busy = (k <= 42);
      exp_done = (k == 43);
      checks++;
      if ({period_end_o, busy_o, done_o} !== {exp_pe, exp_busy, exp_done}) begin
        errs++;
        $display("FAIL single_ctrl k=%0d got pe/busy/done=%b exp=%b", k,
                 {period_end_o, busy_o, done_o}, {exp_pe, exp_busy, exp_done});
      end
      if (k == 2 || k == 22) begin
        checks++;
        if ({reload_o, clr_thres_o, set_thres_o, step_o} !== {8'd9, 8'd5, 8'd0, 2'd0}) begin
          errs++; $display("FAIL single_e0 k=%0d got r/c/s/step=%0d/%0d/%0d/%0d exp=9/5/0/0",
                           k, reload_o, clr_thres_o, set_thres_o, step_o);
        end
      end
      if (k == 23 || k == 45) begin
        checks++;
        if ({reload_o, clr_thres_o, set_thres_o, step_o} !== {8'd9, 8'd2, 8'd0, 2'd1}) begin
          errs++; $display("FAIL single_e1 k=%0d got r/c/s/step=%0d/%0d/%0d/%0d exp=9/2/0/1",
                           k, reload_o, clr_thres_o, set_thres_o, step_o);
        end
      end
    end
    repeat_i = 8'd2; loop_i = 1'b0;
  endtask

  task automatic test_loop();
    logic exp_pe;
    logic [1:0] exp_step;
    repeat_i = 8'd2; last_idx_i = 2'd1; loop_i = 1'b1;
    start_i = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      tick();
      start_i  = 1'b0;
      exp_pe   = (k == 11) || (k == 21) || (k == 32) || (k == 42) || (k == 53) || (k == 63);
      exp_step = ((k >= 23 && k <= 43) || k >= 65) ? 2'd1 : 2'd0;
      checks++;
      if ({period_end_o, busy_o, done_o} !== {exp_pe, 1'b1, 1'b0}) begin
        errs++;
        $display("FAIL loop_ctrl k=%0d got pe/busy/done=%b exp=%b", k,
                 {period_end_o, busy_o, done_o}, {exp_pe, 1'b1, 1'b0});
      end
      if (k >= 2) begin
        checks++;
        if (step_o !== exp_step) begin
          errs++; $display("FAIL loop_step k=%0d got=%0d exp=%0d", k, step_o, exp_step);
        end
      end
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    loop_i = 1'b0;
  endtask

  // repeat=0 acts as 1; e0.reload=0 gives a 1-cycle period.
  task automatic test_fast();
    logic exp_pe, exp_busy, exp_done;
    write_entry(2'd0, 8'd0, 8'd1, 8'd0);
    write_entry(2'd1, 8'd3, 8'd2, 8'd1);
    repeat_i = 8'd0; last_idx_i = 2'd1; loop_i = 1'b0;
    start_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      start_i  = 1'b0;
      exp_pe   = (k == 2) || (k == 7);
      exp_busy = (k <= 7);
      exp_done = (k == 8);
      checks++;
      if ({period_end_o, busy_o, done_o} !== {exp_pe, exp_busy, exp_done}) begin
        errs++;
        $display("FAIL fast_ctrl k=%0d got pe/busy/done=%b exp=%b", k,
                 {period_end_o, busy_o, done_o}, {exp_pe, exp_busy, exp_done});
      end
      if (k == 3 || k == 4) begin
        checks++;
        if (step_o !== ((k == 4) ? 2'd1 : 2'd0)) begin
          errs++; $display("FAIL fast_step k=%0d got=%0d exp=%0d", k, step_o, (k == 4) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_stop();
    write_entry(2'd0, 8'd9, 8'd5, 8'd0);
    write_entry(2'd1, 8'd9, 8'd2, 8'd0);
    repeat_i = 8'd2; last_idx_i = 2'd1; loop_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    checks++;
    if ({busy_o, done_o, reload_o, clr_thres_o, set_thres_o} !== 26'h0) begin
      errs++; $display("FAIL stop_out got busy/done=%b%b r/c/s=%0d/%0d/%0d exp all 0",
                       busy_o, done_o, reload_o, clr_thres_o, set_thres_o);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({busy_o, done_o} !== 2'b00) begin
        errs++; $display("FAIL stop_idle k=%0d got busy/done=%b%b exp=00", k, busy_o, done_o);
      end
    end
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errs++; $display("FAIL start_stop_idle got busy=%b exp=0", busy_o);
    end
  endtask

  task automatic test_write_active();
    repeat_i = 8'd2; last_idx_i = 2'd1; loop_i = 1'b1;
    start_i = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      tick();
      start_i = 1'b0;
      wr_en_i = (k == 25);
      wr_addr_i = 2'd1;
      wr_data_i = {8'd9, 8'd7, 8'd3};
      if (k == 30) begin
        checks++;
        if ({clr_thres_o, set_thres_o, step_o} !== {8'd2, 8'd0, 2'd1}) begin
          errs++; $display("FAIL wr_active_old got c/s/step=%0d/%0d/%0d exp=2/0/1",
                           clr_thres_o, set_thres_o, step_o);
        end
      end
      if (k == 65) begin
        checks++;
        if ({clr_thres_o, set_thres_o, step_o} !== {8'd7, 8'd3, 2'd1}) begin
          errs++; $display("FAIL wr_active_new got c/s/step=%0d/%0d/%0d exp=7/3/1",
                           clr_thres_o, set_thres_o, step_o);
        end
      end
    end
    wr_en_i = 1'b0;
    res_i = 1'b1;
    tick();
    res_i = 1'b0;
    loop_i = 1'b0;
    checks++;
    if ({busy_o, done_o, period_end_o, step_o, reload_o, clr_thres_o, set_thres_o} !== 29'h0) begin
      errs++; $display("FAIL reset_mid_run got busy=%b step=%0d r/c/s=%0d/%0d/%0d exp all 0",
                       busy_o, step_o, reload_o, clr_thres_o, set_thres_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_loop();
    test_fast();
    test_stop();
    test_write_active();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
